// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-to-decode handshake: head-of-queue instruction and byte PC with valid/ready.
interface inst_fetch_ctrl_if #(
  parameter int unsigned PC_W = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [PC_W-1:0] if_pc;

  modport master (output if_valid, output if_inst, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_inst, input if_pc, output if_ready);
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: PC, combinational ROM addressing, fetch queue, branch redirect.
// Optional stall performance counter enabled by defining IF_PERF_EN.
module inst_fetch_ctrl #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  inst_fetch_ctrl_if.master id_bus,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic [15:0]       perf_stall
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [PC_W-1:0] q_pc   [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic            pop, push;

  assign rom_addr        = pc[ADDR_W+1:2];
  assign id_bus.if_valid = (count != '0);
  assign id_bus.if_inst  = q_inst[head];
  assign id_bus.if_pc    = q_pc[head];

  assign pop  = id_bus.if_valid & id_bus.if_ready;
  assign push = ~br_taken & ((count < DEPTH_C) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= br_target & ~(PC_W'(3));
    end else if (push) begin
      pc <= pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (br_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]   <= pc;
        q_inst[tail] <= rom_inst;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      // Simultaneous push and pop (including on a full queue) leaves count unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef IF_PERF_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_bus.if_valid && !id_bus.if_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
  assign perf_stall = stall_cnt;
`else
  assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small combinational ROM model.
module tb_inst_fetch_ctrl;
  logic        clk;
  logic        rst;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic [15:0] perf_stall;
  int checks;
  int errors;
  int perf_on;

  inst_fetch_ctrl_if #(.PC_W(32)) bus ();

  inst_fetch_ctrl #(
    .PC_W(32), .ADDR_W(6), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .id_bus    (bus),
    .br_taken  (br_taken),
    .br_target (br_target),
    .perf_stall(perf_stall)
  );

  always_comb begin
    rom_inst = 32'h0;
    case (rom_addr)
      6'd1: rom_inst = 32'h30001043;
      6'd2: rom_inst = 32'h00101041;
      6'd3: rom_inst = 32'h34001045;
      default: rom_inst = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst);
    chk({tag, "_valid"}, 64'(bus.if_valid), 64'(v));
    if (v) begin
      chk({tag, "_pc"}, 64'(bus.if_pc), 64'(pc));
      chk({tag, "_inst"}, 64'(bus.if_inst), 64'(inst));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef IF_PERF_EN
    perf_on = 1;
`else
    perf_on = 0;
`endif
    rst = 1'b1;
    bus.if_ready = 1'b1;
    br_taken = 1'b0;
    br_target = '0;
    #12;
    chk("rst_valid", 64'(bus.if_valid), 64'(0));
    chk("rst_pc", 64'(bus.if_pc), 64'(0));
    chk("rst_inst", 64'(bus.if_inst), 64'(0));
    chk("rst_addr", 64'(rom_addr), 64'(0));
    chk("rst_perf", 64'(perf_stall), 64'(0));
    step();
    rst = 1'b0;

    // Streaming after reset.
    step();
    head("c1", 1'b1, 32'h0, 32'h0);
    step();
    head("c2", 1'b1, 32'h4, 32'h30001043);
    chk("c2_addr", 64'(rom_addr), 64'(2));

    // Stall for 5 cycles with head at pc=4.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("stall", 1'b1, 32'h4, 32'h30001043);
      chk("stall_addr", 64'(rom_addr), 64'(3));
    end
    chk("stall_perf", 64'(perf_stall), 64'(perf_on * 5));
    bus.if_ready = 1'b1;
    step();
    head("rel8", 1'b1, 32'h8, 32'h00101041);
    chk("rel8_addr", 64'(rom_addr), 64'(4));

    // Redirect while full; unaligned target forced to word boundary.
    br_taken = 1'b1;
    br_target = 32'h0000000E;
    step();
    br_taken = 1'b0;
    chk("br_valid", 64'(bus.if_valid), 64'(0));
    chk("br_addr", 64'(rom_addr), 64'(3));
    step();
    head("br_tgt", 1'b1, 32'hC, 32'h34001045);

    // ROM index wrap 63 -> 0.
    br_taken = 1'b1;
    br_target = 32'h000000FC;
    step();
    br_taken = 1'b0;
    chk("wrap_valid", 64'(bus.if_valid), 64'(0));
    chk("wrap_addr63", 64'(rom_addr), 64'(63));
    step();
    head("wrap_fc", 1'b1, 32'hFC, 32'h0);
    chk("wrap_addr0", 64'(rom_addr), 64'(0));
    step();
    head("wrap_100", 1'b1, 32'h100, 32'h0);

    // Async reset mid-stall with a full queue.
    bus.if_ready = 1'b0;
    step();
    step();
    chk("pre_rst_addr", 64'(rom_addr), 64'(2));
    chk("pre_rst_perf", 64'(perf_stall), 64'(perf_on * 7));
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.if_valid), 64'(0));
    chk("arst_addr", 64'(rom_addr), 64'(0));
    chk("arst_perf", 64'(perf_stall), 64'(0));
    step();
    rst = 1'b0;
    bus.if_ready = 1'b1;
    step();
    head("rs1", 1'b1, 32'h0, 32'h0);
    step();
    head("rs2", 1'b1, 32'h4, 32'h30001043);

    // 10 stall cycles for the performance counter.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("perf10", 64'(perf_stall), 64'(perf_on * 10));
    head("perf_hold", 1'b1, 32'h4, 32'h30001043);
    bus.if_ready = 1'b1;
    step();
    head("post8", 1'b1, 32'h8, 32'h00101041);
    step();
    head("post12", 1'b1, 32'hC, 32'h34001045);
    chk("perf_final", 64'(perf_stall), 64'(perf_on * 10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
